hack_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the Hack CPU. It supersedes the single-cycle combinational instruction decoder.
- Sequences FETCH, DECODE, optional data-memory read, optional data-memory write, then EXEC.
- Uses ready/request handshakes to instruction and data memory, has a bounded wait timeout, and counts retired instructions.
- Sits between the instruction ROM / data RAM and the A/D/PC registers and ALU of the datapath.

---
 rtl/hack_ctrl_fsm.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_hack_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_ctrl_fsm.sv
// hack_ctrl_fsm: multi-cycle control unit for the Hack CPU.
// Sequences FETCH -> DECODE -> [MEM_RD] -> [MEM_WR] -> EXEC with req/ready
// handshakes to instruction and data memory, a bounded wait timeout that
// traps into an absorbing ERR state, and a retired-instruction counter.
// Optional build macro: HACK_ILLEGAL_TRAP_EN traps C-instructions whose
// IR[14:13] != 2'b11 into ERR and raises a sticky 'illegal' flag.
module hack_ctrl_fsm #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned RET_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr,
    output logic              imem_req,
    input  logic              imem_ready,
    output logic              dmem_req,
    input  logic              dmem_ready,
    input  logic              Zy,
    input  logic              Cy,
    output logic              ir_load,
    output logic              a,
    output logic [5:0]        alu_ctl,
    output logic              a_from_instr,
    output logic              we_a,
    output logic              we_d,
    output logic              we_m,
    output logic              PC_e,
    output logic              pc_inc,
    output logic              bus_err,
    output logic              illegal,
    output logic [RET_W-1:0]  retired
);

    localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_EXEC,
        S_ERR
    } state_t;

    state_t            r_state;

    // decoded instruction fields kept for the life of the instruction
    logic              r_is_c;
    logic [2:0]        r_dst;
    logic [2:0]        r_jmp;

    logic [WAIT_W-1:0] r_wait_cnt;

    logic              r_imem_req;
    logic              r_dmem_req;
    logic              r_ir_load;
    logic              r_a;
    logic [5:0]        r_alu_ctl;
    logic              r_a_from_instr;
    logic              r_we_a;
    logic              r_we_d;
    logic              r_we_m;
    logic              r_pc_e;
    logic              r_pc_inc;
    logic              r_bus_err;
    logic [RET_W-1:0]  r_retired;

    logic              w_waiting;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_timeout;
    logic              w_jmp;
    logic              w_exec_we_a;
    logic              w_exec_we_d;
    logic              w_exec_afi;

`ifdef HACK_ILLEGAL_TRAP_EN
    logic [1:0]        r_ext;
    logic              r_illegal;
    logic              w_trap;
`endif

    // Bits above 15 carry no meaning for decode.
    if (DATA_W > 16) begin : g_wide
        logic w_unused_instr_hi;
        assign w_unused_instr_hi = ^instr[DATA_W-1:16];
    end

    // Handshake wait tracking and the EXEC-cycle controls derived from IR and flags
    always_comb begin
        w_waiting   = ((r_state == S_FETCH) && r_imem_req && !imem_ready) ||
                      (((r_state == S_MEM_RD) || (r_state == S_MEM_WR)) &&
                       r_dmem_req && !dmem_ready);
        w_wait_next = r_wait_cnt + WAIT_W'(1);
        w_timeout   = (WAIT_MAX != 0) && w_waiting && (w_wait_next == WAIT_LIM);
        // ALU flags are sampled in the cycle that hands over to EXEC; the
        // ALU inputs (A/D/M and alu_ctl) are already stable at that point.
        w_jmp       = r_is_c & ((r_jmp[2] & Cy) | (r_jmp[1] & Zy) |
                                (r_jmp[0] & ~Cy & ~Zy));
        w_exec_we_a = r_is_c ? r_dst[2] : 1'b1;
        w_exec_we_d = r_is_c & r_dst[1];
        w_exec_afi  = ~r_is_c;
    end

`ifdef HACK_ILLEGAL_TRAP_EN
    assign w_trap = r_is_c && (r_ext != 2'b11);
`else
    logic w_unused_ext;
    assign w_unused_ext = ^instr[14:13];
`endif

    // Control FSM: state sequencing with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_FETCH;
            r_is_c         <= 1'b0;
            r_dst          <= '0;
            r_jmp          <= '0;
            r_wait_cnt     <= '0;
            r_imem_req     <= 1'b0;
            r_dmem_req     <= 1'b0;
            r_ir_load      <= 1'b0;
            r_a            <= 1'b0;
            r_alu_ctl      <= '0;
            r_a_from_instr <= 1'b0;
            r_we_a         <= 1'b0;
            r_we_d         <= 1'b0;
            r_we_m         <= 1'b0;
            r_pc_e         <= 1'b0;
            r_pc_inc       <= 1'b0;
            r_bus_err      <= 1'b0;
            r_retired      <= '0;
`ifdef HACK_ILLEGAL_TRAP_EN
            r_ext          <= '0;
            r_illegal      <= 1'b0;
`endif
        end else begin
            // single-cycle pulses default low
            r_ir_load      <= 1'b0;
            r_a_from_instr <= 1'b0;
            r_we_a         <= 1'b0;
            r_we_d         <= 1'b0;
            r_pc_e         <= 1'b0;
            r_pc_inc       <= 1'b0;

            if (w_waiting && (WAIT_MAX != 0)) begin
                r_wait_cnt <= w_wait_next;
            end

            if (w_timeout) begin
                r_state    <= S_ERR;
                r_bus_err  <= 1'b1;
                r_imem_req <= 1'b0;
                r_dmem_req <= 1'b0;
                r_we_m     <= 1'b0;
                r_a        <= 1'b0;
                r_alu_ctl  <= '0;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (!r_imem_req) begin
                            // first fetch after reset: raise the request
                            r_imem_req <= 1'b1;
                            r_wait_cnt <= '0;
                        end else if (imem_ready) begin
                            r_imem_req <= 1'b0;
                            r_ir_load  <= 1'b1;
                            r_is_c     <= instr[15];
                            r_dst      <= instr[5:3];
                            r_jmp      <= instr[2:0];
                            r_a        <= instr[15] & instr[12];
                            r_alu_ctl  <= instr[15] ? instr[11:6] : 6'b000000;
`ifdef HACK_ILLEGAL_TRAP_EN
                            r_ext      <= instr[14:13];
`endif
                            r_state    <= S_DECODE;
                        end
                    end

                    S_DECODE: begin
`ifdef HACK_ILLEGAL_TRAP_EN
                        if (w_trap) begin
                            r_illegal <= 1'b1;
                            r_a       <= 1'b0;
                            r_alu_ctl <= '0;
                            r_state   <= S_ERR;
                        end else
`endif
                        if (r_is_c && r_a) begin
                            r_dmem_req <= 1'b1;
                            r_we_m     <= 1'b0;
                            r_wait_cnt <= '0;
                            r_state    <= S_MEM_RD;
                        end else if (r_is_c && r_dst[0]) begin
                            r_dmem_req <= 1'b1;
                            r_we_m     <= 1'b1;
                            r_wait_cnt <= '0;
                            r_state    <= S_MEM_WR;
                        end else begin
                            r_we_a         <= w_exec_we_a;
                            r_we_d         <= w_exec_we_d;
                            r_a_from_instr <= w_exec_afi;
                            r_pc_e         <= w_jmp;
                            r_pc_inc       <= ~w_jmp;
                            r_retired      <= r_retired + RET_W'(1);
                            r_state        <= S_EXEC;
                        end
                    end

                    S_MEM_RD: begin
                        if (dmem_ready) begin
                            if (r_dst[0]) begin
                                r_we_m     <= 1'b1;
                                r_wait_cnt <= '0;
                                r_state    <= S_MEM_WR;
                            end else begin
                                r_dmem_req     <= 1'b0;
                                r_we_a         <= w_exec_we_a;
                                r_we_d         <= w_exec_we_d;
                                r_a_from_instr <= w_exec_afi;
                                r_pc_e         <= w_jmp;
                                r_pc_inc       <= ~w_jmp;
                                r_retired      <= r_retired + RET_W'(1);
                                r_state        <= S_EXEC;
                            end
                        end
                    end

                    S_MEM_WR: begin
                        // A/D writes wait until EXEC so M gets the result of the old A/D
                        if (dmem_ready) begin
                            r_dmem_req     <= 1'b0;
                            r_we_m         <= 1'b0;
                            r_we_a         <= w_exec_we_a;
                            r_we_d         <= w_exec_we_d;
                            r_a_from_instr <= w_exec_afi;
                            r_pc_e         <= w_jmp;
                            r_pc_inc       <= ~w_jmp;
                            r_retired      <= r_retired + RET_W'(1);
                            r_state        <= S_EXEC;
                        end
                    end

                    S_EXEC: begin
                        r_imem_req <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= S_FETCH;
                    end

                    S_ERR: begin
                        r_imem_req <= 1'b0;
                        r_dmem_req <= 1'b0;
                        r_we_m     <= 1'b0;
                        r_state    <= S_ERR;
                    end

                    default: begin
                        r_state <= S_ERR;
                    end
                endcase
            end
        end
    end

    assign imem_req     = r_imem_req;
    assign dmem_req     = r_dmem_req;
    assign ir_load      = r_ir_load;
    assign a            = r_a;
    assign alu_ctl      = r_alu_ctl;
    assign a_from_instr = r_a_from_instr;
    assign we_a         = r_we_a;
    assign we_d         = r_we_d;
    assign we_m         = r_we_m;
    assign PC_e         = r_pc_e;
    assign pc_inc       = r_pc_inc;
    assign bus_err      = r_bus_err;
    assign retired      = r_retired;
`ifdef HACK_ILLEGAL_TRAP_EN
    assign illegal      = r_illegal;
`else
    assign illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_hack_ctrl_fsm.sv
// Self-checking bench for hack_ctrl_fsm: a table of instruction vectors with
// hand-computed EXEC controls and memory-cycle counts, plus directed
// sequences for reset, mid-handshake reset, timeout and the illegal trap.
module tb_hack_ctrl_fsm;

    localparam int DATA_W   = 16;
    localparam int WAIT_MAX = 4;
    localparam int RET_W    = 32;

`ifdef HACK_ILLEGAL_TRAP_EN
    localparam logic [15:0] C_EXT = 16'h6000;
`else
    localparam logic [15:0] C_EXT = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] instr;
    logic              imem_req, imem_ready;
    logic              dmem_req, dmem_ready;
    logic              Zy, Cy;
    logic              ir_load, a, a_from_instr, we_a, we_d, we_m, PC_e, pc_inc;
    logic              bus_err, illegal;
    logic [5:0]        alu_ctl;
    logic [RET_W-1:0]  retired;

    always #5 clk = ~clk;

    hack_ctrl_fsm #(.DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX), .RET_W(RET_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .Zy(Zy), .Cy(Cy), .ir_load(ir_load), .a(a), .alu_ctl(alu_ctl),
        .a_from_instr(a_from_instr), .we_a(we_a), .we_d(we_d), .we_m(we_m),
        .PC_e(PC_e), .pc_inc(pc_inc), .bus_err(bus_err), .illegal(illegal),
        .retired(retired)
    );

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    typedef struct {
        logic [15:0] ins;
        logic        zy, cy;
        int          wait_c;
        int          rd_n, wr_n;
        logic        we_a, we_d, afi, pce, pci, a;
        logic [5:0]  alu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] ins, input logic zy, input logic cy,
                                input int wait_c, input int rd_n, input int wr_n,
                                input logic wa, input logic wd, input logic afi,
                                input logic pce, input logic pci, input logic av,
                                input logic [5:0] alu);
        vec_t v;
        v.ins = ins; v.zy = zy; v.cy = cy; v.wait_c = wait_c;
        v.rd_n = rd_n; v.wr_n = wr_n; v.we_a = wa; v.we_d = wd; v.afi = afi;
        v.pce = pce; v.pci = pci; v.a = av; v.alu = alu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_imem_req(output bit got);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (imem_req) got = 1'b1;
        end
        chk("imem_req_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit         got;
        int         rd_n, wr_n, ph;
        logic [1:0] key, pkey;
        string      t;
        t = $sformatf("v%0d_%h", idx, v.ins);
        Zy = v.zy;
        Cy = v.cy;
        wait_imem_req(got);
        if (!got) return;
        instr = v.ins;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        instr = '0;
        chk({t, "_ir_load"}, {63'd0, ir_load}, 64'd1);
        rd_n = 0; wr_n = 0; ph = 0; pkey = 2'b00; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            if (c > 0) @(negedge clk);
            key = {dmem_req, we_m};
            if (key != pkey) ph = 0;
            pkey = key;
            if (dmem_req) begin
                ph++;
                if (we_m) wr_n++; else rd_n++;
            end
            dmem_ready = dmem_req && (ph > v.wait_c);
            if (we_a | we_d | pc_inc | PC_e) got = 1'b1;
        end
        dmem_ready = 1'b0;
        chk({t, "_exec_reached"}, {63'd0, got}, 64'd1);
        if (!got) return;
        exp_ret++;
        chk({t, "_we_a"},    {63'd0, we_a},         {63'd0, v.we_a});
        chk({t, "_we_d"},    {63'd0, we_d},         {63'd0, v.we_d});
        chk({t, "_afi"},     {63'd0, a_from_instr}, {63'd0, v.afi});
        chk({t, "_PC_e"},    {63'd0, PC_e},         {63'd0, v.pce});
        chk({t, "_pc_inc"},  {63'd0, pc_inc},       {63'd0, v.pci});
        chk({t, "_a"},       {63'd0, a},            {63'd0, v.a});
        chk({t, "_alu_ctl"}, {58'd0, alu_ctl},      {58'd0, v.alu});
        chk({t, "_dmem_req"},{63'd0, dmem_req},     64'd0);
        chk({t, "_illegal"}, {63'd0, illegal},      64'd0);
        chk({t, "_retired"}, {32'd0, retired},      64'(exp_ret));
        chk({t, "_rd_cycles"}, 64'(rd_n), 64'(v.rd_n));
        chk({t, "_wr_cycles"}, 64'(wr_n), 64'(v.wr_n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
        Zy = 1'b0; Cy = 1'b0;

        //             ins              zy cy wt rd wr wa wd afi pce pci a  alu
        vecs.push_back(mk(16'h0056,       0, 0, 0, 0, 0, 1, 0, 1,  0,  1,  0, 6'o00));
`ifndef HACK_ILLEGAL_TRAP_EN
        vecs.push_back(mk(16'h8045,       1, 0, 0, 0, 0, 0, 0, 0,  0,  1,  0, 6'b000001));
        vecs.push_back(mk(16'h8045,       0, 1, 0, 0, 0, 0, 0, 0,  1,  0,  0, 6'b000001));
`endif
        vecs.push_back(mk(16'hE045,       0, 1, 0, 0, 0, 0, 0, 0,  1,  0,  0, 6'b000001));
        vecs.push_back(mk(16'h813B|C_EXT, 1, 0, 3, 0, 4, 1, 1, 0,  1,  0,  0, 6'b000100));
        vecs.push_back(mk(16'h9C10|C_EXT, 0, 0, 2, 3, 0, 0, 1, 0,  0,  1,  1, 6'b110000));
        vecs.push_back(mk(16'hFDC8,       0, 0, 1, 2, 2, 0, 0, 0,  0,  1,  1, 6'b110111));
        vecs.push_back(mk(16'hE008,       0, 0, 0, 0, 1, 0, 0, 0,  0,  1,  0, 6'b000000));
        vecs.push_back(mk(16'hEA87,       0, 0, 0, 0, 0, 0, 0, 0,  1,  0,  0, 6'b101010));
        vecs.push_back(mk(16'h7FFF,       1, 1, 0, 0, 0, 1, 0, 1,  0,  1,  0, 6'b000000));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_enables", {58'd0, ir_load, we_a, we_d, we_m, PC_e, pc_inc}, 64'd0);
        chk("rst_flags", {61'd0, bus_err, illegal, a_from_instr}, 64'd0);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // reset while MEM_WR is waiting on dmem_ready
        Zy = 1'b1; Cy = 1'b0;
        wait_imem_req(got);
        instr = 16'h813B | C_EXT;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (we_m) got = 1'b1;
        end
        chk("midrst_we_m_seen", {63'd0, got}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_mem", {62'd0, dmem_req, we_m}, 64'd0);
        chk("midrst_wr", {61'd0, we_a, we_d, PC_e}, 64'd0);
        chk("midrst_retired", {32'd0, retired}, 64'd0);
        rst_n = 1'b1;
        exp_ret = 0;
        run_vec(vecs[0], 100);

        // timeout on instruction fetch
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_imem_req(got);
        repeat (3) @(negedge clk);
        chk("to_bus_err_before", {63'd0, bus_err}, 64'd0);
        chk("to_imem_req_before", {63'd0, imem_req}, 64'd1);
        @(negedge clk);
        chk("to_bus_err", {63'd0, bus_err}, 64'd1);
        chk("to_imem_req", {63'd0, imem_req}, 64'd0);
        imem_ready = 1'b1;
        instr = 16'h0056;
        repeat (3) @(negedge clk);
        chk("err_absorb", {61'd0, bus_err, imem_req, ir_load}, 64'h4);
        imem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("err_rst_bus_err", {63'd0, bus_err}, 64'd0);
        chk("err_rst_retired", {32'd0, retired}, 64'd0);
        rst_n = 1'b1;

`ifdef HACK_ILLEGAL_TRAP_EN
        // illegal C-instruction trap
        begin
            int en_hits;
            en_hits = 0;
            Zy = 1'b0; Cy = 1'b1;
            wait_imem_req(got);
            instr = 16'h8045;
            imem_ready = 1'b1;
            @(negedge clk);
            imem_ready = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (we_a | we_d | we_m | PC_e | pc_inc | dmem_req) en_hits++;
            end
            chk("ill_flag", {63'd0, illegal}, 64'd1);
            chk("ill_no_enables", 64'(en_hits), 64'd0);
            chk("ill_retired", {32'd0, retired}, 64'd0);
            chk("ill_imem_req", {63'd0, imem_req}, 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
